hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Register-write hazard scoreboard: per-register outstanding-write counters,
// issue stall generation and a RUN/DRAIN/DRAINED quiesce FSM.
// Optional stall-cycle statistics counter enabled by SCOREBOARD_STATS_EN.

module hazard_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic underflow
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || flush)
      cnt <= '0;
    else if (inc && !dec)
      cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign busy      = |cnt;
  assign full      = &cnt;
  assign underflow = dec && (cnt == '0);
endmodule

module hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_uses_rs,
  input  logic        issue_uses_rt,
  input  logic        issue_RegWrite,
  input  logic [4:0]  issue_rw,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rw,
  input  logic        UART_write_enable,
  input  logic        flush,
  input  logic        drain_req,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] busy_vec,
  output logic        drained,
  output logic        wb_err
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t      state, state_nxt;
  logic [31:0] busy_raw, full, underflow;
  logic        retire;

  assign retire = wb_RegWrite || UART_write_enable;

  // Register 0 is hardwired idle; its writes and retires are ignored.
  assign busy_raw[0]  = 1'b0;
  assign full[0]      = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_reg
    hazard_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (CLK),
      .reset     (reset),
      .flush     (flush),
      .inc       (issue_fire && issue_RegWrite && issue_rw == 5'(i)),
      .dec       (retire && wb_rw == 5'(i)),
      .busy      (busy_raw[i]),
      .full      (full[i]),
      .underflow (underflow[i])
    );
  end

  // Hazards are evaluated on registered counters only: no same-cycle bypass.
  assign stall = issue_valid && ((state != RUN)
                 || (issue_uses_rs && busy_raw[issue_rs])
                 || (issue_uses_rt && busy_raw[issue_rt])
                 || (issue_RegWrite && full[issue_rw]));
  assign issue_fire = issue_valid && !stall;

  assign busy_vec = reset ? 32'd0 : busy_raw;
  assign drained  = (state == DRAINED) && !reset;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= RUN;
      wb_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      wb_err <= wb_err || (|underflow);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (busy_raw == 32'd0) state_nxt = DRAINED;
      DRAINED: if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge CLK) begin
    if (reset)
      stall_cycles <= 32'd0;
    else if (stall)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule
